// File: rtl/lsu_pkg.sv
// lsu_pkg
//   Shared definitions for the load/store alignment unit.
//   - SZ_B/SZ_H/SZ_W/SZ_D : req_size encodings (log2 of access bytes)
//   - lsu_state_t + ST_*  : FSM state type and encodings
//   - lsu_off_w()         : width of the in-word byte offset for a bus width
//   - lsu_shamt_w()       : width of a bit-shift amount across a two-word window
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE  = 3'd0;
    localparam lsu_state_t ST_REQ0  = 3'd1;
    localparam lsu_state_t ST_WAIT0 = 3'd2;
    localparam lsu_state_t ST_REQ1  = 3'd3;
    localparam lsu_state_t ST_WAIT1 = 3'd4;
    localparam lsu_state_t ST_RESP  = 3'd5;

    function automatic int unsigned lsu_off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int unsigned lsu_shamt_w(input int unsigned data_w);
        return $clog2(2 * data_w);
    endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// lsu_lane_shift
//   Combinational lane arithmetic for one access: byte-enable masks and
//   lane-positioned write data for both bus beats, the split flag, and the
//   merged, sign/zero-extended load result.
//   Ports:
//     off_i        in  in-word byte offset of the access
//     size_i       in  log2 of access bytes
//     unsigned_i   in  1 = zero-extend load data
//     wdata_i      in  right-justified store data
//     rdata_pair_i in  {hi, lo} captured read beats
//     byteen0_o    out beat-0 byte enables
//     byteen1_o    out beat-1 byte enables
//     wdata0_o     out beat-0 write data
//     wdata1_o     out beat-1 write data
//     split_o      out access crosses the bus-word boundary
//     rdata_o      out extended load data
//   Build option: with LSU_MISALIGN_TRAP_EN defined, crossing accesses are
//   trapped upstream, so the beat-1 and split outputs are tied to zero.
module lsu_lane_shift import lsu_pkg::*; #(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = lsu_off_w(DATA_W)
) (
    input  logic [OFF_W-1:0]    off_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [2*DATA_W-1:0] rdata_pair_i,
    output logic [NB-1:0]       byteen0_o,
    output logic [NB-1:0]       byteen1_o,
    output logic [DATA_W-1:0]   wdata0_o,
    output logic [DATA_W-1:0]   wdata1_o,
    output logic                split_o,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int SH_W = lsu_shamt_w(DATA_W);

    logic [2*NB-1:0]     base_mask;
    logic [2*NB-1:0]     mask;
    logic [4:0]          size_bytes;
    logic [SH_W-1:0]     sh_lo;
    logic [SH_W-1:0]     sh_hi;
    logic [2*DATA_W-1:0] raw;
    logic                sign_bit;
    logic                fill;

    always_comb begin
        case (size_i)
            SZ_B:    begin base_mask = (2*NB)'(16'h0001); size_bytes = 5'd1; end
            SZ_H:    begin base_mask = (2*NB)'(16'h0003); size_bytes = 5'd2; end
            SZ_W:    begin base_mask = (2*NB)'(16'h000F); size_bytes = 5'd4; end
            default: begin base_mask = (2*NB)'(16'h00FF); size_bytes = 5'd8; end
        endcase
    end

    // mask spans two bus words so the upper half is the beat-1 enable set.
    assign mask  = base_mask << off_i;
    assign sh_lo = SH_W'(off_i) << 3;
    // When off is 0 this shift equals DATA_W and yields zero, which is fine
    // because beat 1 only exists for off > 0.
    assign sh_hi = (SH_W'(NB) - SH_W'(off_i)) << 3;

    assign byteen0_o = mask[NB-1:0];
    assign wdata0_o  = wdata_i << sh_lo;

`ifdef LSU_MISALIGN_TRAP_EN
    assign byteen1_o = '0;
    assign wdata1_o  = '0;
    assign split_o   = 1'b0;
`else
    assign byteen1_o = mask[2*NB-1:NB];
    assign wdata1_o  = wdata_i >> sh_hi;
    assign split_o   = (5'(off_i) + size_bytes) > 5'(NB);
`endif

    assign raw = rdata_pair_i >> sh_lo;

    always_comb begin
        case (size_i)
            SZ_B:    sign_bit = raw[7];
            SZ_H:    sign_bit = raw[15];
            SZ_W:    sign_bit = raw[31];
            default: sign_bit = raw[63];
        endcase
        fill    = sign_bit & ~unsigned_i;
        rdata_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rdata_o[i] = (i < 8 * int'(size_bytes)) ? raw[i] : fill;
        end
    end

endmodule

// File: rtl/lsu_align_unit.sv
// lsu_align_unit
//   Load/store alignment unit between the MEM stage and the data bus.
//   Accepts one request at a time, issues one or two bus beats (two when
//   the access crosses a bus-word boundary), merges the read beats and
//   returns extended load data with a one-cycle rsp_valid pulse.
//   Handshakes: a request transfers in the cycle req_valid && req_ready;
//   a bus beat transfers in the cycle m_req && m_gnt, with m_addr/m_byteen/
//   m_wdata/m_we held stable until then; m_rvalid completes the beat in the
//   following WAIT state. rsp_valid has no backpressure.
//   Ports:
//     clk, reset (async, active low)
//     req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//     rsp_valid/rsp_rdata/rsp_err
//     m_req/m_gnt/m_we/m_addr/m_byteen/m_wdata/m_rvalid/m_rdata
//   Build option LSU_MISALIGN_TRAP_EN: accesses not naturally aligned
//   respond with rsp_err and never reach the bus; no split path exists.
module lsu_align_unit import lsu_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              m_req,
    input  logic              m_gnt,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W/8-1:0] m_byteen,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = lsu_off_w(DATA_W);

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_q;

    logic              accept;
    logic              acc_err;
    logic              split;
    logic              beat1;
    logic [ADDR_W-1:0] base_addr;
    logic [NB-1:0]     be0, be1;
    logic [DATA_W-1:0] wd0, wd1;
    logic [DATA_W-1:0] rdata_ext;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Requests that must not reach the bus are decided at accept time.
`ifdef LSU_MISALIGN_TRAP_EN
    logic [3:0] align_m;
    always_comb begin
        case (req_size)
            SZ_B:    align_m = 4'd0;
            SZ_H:    align_m = 4'd1;
            SZ_W:    align_m = 4'd3;
            default: align_m = 4'd7;
        endcase
        acc_err = (req_size == SZ_D) && (DATA_W != 64);
        if ((4'(req_addr[OFF_W-1:0]) & align_m) != 4'd0) begin
            acc_err = 1'b1;
        end
    end
`else
    always_comb begin
        acc_err = (req_size == SZ_D) && (DATA_W != 64);
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = acc_err ? ST_RESP : ST_REQ0;
            ST_REQ0:  if (m_gnt)     state_d = ST_WAIT0;
            ST_WAIT0: begin
                if (m_rvalid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = ST_RESP;
`else
                    state_d = split ? ST_REQ1 : ST_RESP;
`endif
                end
            end
            ST_REQ1:  if (m_gnt)     state_d = ST_WAIT1;
            ST_WAIT1: if (m_rvalid)  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= acc_err;
                lo_q    <= '0;
                hi_q    <= '0;
            end
            if ((state_q == ST_WAIT0) && m_rvalid) lo_q <= m_rdata;
            if ((state_q == ST_WAIT1) && m_rvalid) hi_q <= m_rdata;
        end
    end

    lsu_lane_shift #(.DATA_W(DATA_W)) u_lane (
        .off_i        (addr_q[OFF_W-1:0]),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .rdata_pair_i ({hi_q, lo_q}),
        .byteen0_o    (be0),
        .byteen1_o    (be1),
        .wdata0_o     (wd0),
        .wdata1_o     (wd1),
        .split_o      (split),
        .rdata_o      (rdata_ext)
    );

    // Bus outputs are forced to zero outside REQn so idle/reset values are clean.
    assign beat1     = (state_q == ST_REQ1);
    assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign m_req     = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    assign m_we      = m_req & we_q;
    assign m_addr    = m_req ? (beat1 ? base_addr + ADDR_W'(NB) : base_addr) : '0;
    assign m_byteen  = m_req ? (beat1 ? be1 : be0) : '0;
    assign m_wdata   = (m_req && we_q) ? (beat1 ? wd1 : wd0) : '0;

    assign req_ready = reset && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? rdata_ext : '0;

endmodule

// File: tb/tb_lsu_align_unit.sv
// tb_lsu_align_unit
//   Bench for lsu_align_unit (DATA_W=32). A byte-addressed slave memory
//   answers bus beats with programmable gnt/rvalid delays; a reference
//   memory is updated from the request alone (bytes addr..addr+S-1), so
//   expected load data, error, beat count and latency come from the
//   access rules rather than lane arithmetic.
//   Honours LSU_MISALIGN_TRAP_EN in its expectations.
module tb_lsu_align_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int NB     = 4;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              m_req, m_gnt, m_we, m_rvalid;
    logic [ADDR_W-1:0] m_addr;
    logic [NB-1:0]     m_byteen;
    logic [DATA_W-1:0] m_wdata, m_rdata;

    always #5 clk = ~clk;

    lsu_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .m_req        (m_req),
        .m_gnt        (m_gnt),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_byteen     (m_byteen),
        .m_wdata      (m_wdata),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  slave_mem [bit [31:0]];
    logic [7:0]  ref_mem   [bit [31:0]];
    logic [31:0] exp_q[$];

    int          beat_cnt;
    logic [31:0] beat_addr [2];
    logic [3:0]  beat_be   [2];
    logic [31:0] beat_wd   [2];
    logic        got_rsp;
    int          rsp_cyc;
    logic [31:0] rsp_rd;
    logic        rsp_er;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] default_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] slave_byte(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : default_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : default_byte(a);
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            slave_mem[a + 32'(k)] = w[8*k +: 8];
            ref_mem[a + 32'(k)]   = w[8*k +: 8];
        end
    endtask

    // Reference: an access touches bytes addr..addr+S-1 (little endian).
    function automatic void ref_access(input logic we, input logic [1:0] sz, input logic uns,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic err, output int beats, output logic [31:0] rd);
        int s;
        int off;
        s   = 1 << sz;
        off = int'(addr % NB);
        err = (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((off % s) != 0) err = 1'b1;
`endif
        beats = err ? 0 : ((off + s > NB) ? 2 : 1);
        rd    = '0;
        if (!err) begin
            for (int k = 0; k < s; k++) begin
                if (we) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
                else    rd[8*k +: 8] = ref_byte(addr + 32'(k));
            end
            if (!we && !uns && s < 4 && rd[8*s-1]) begin
                for (int j = 8 * s; j < 32; j++) rd[j] = 1'b1;
            end
        end
    endfunction

    // ---------------- driver: one request plus bus slave ----------------
    task automatic do_access(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int gd, input int rvd);
        int          cyc, gcnt, rcnt;
        logic        seen;
        logic [31:0] f_addr, f_wd, pend_rd;
        logic [3:0]  f_be;
        beat_cnt = 0; got_rsp = 1'b0; rsp_cyc = -1; rsp_rd = '0; rsp_er = 1'b0;
        seen = 1'b0; f_addr = '0; f_wd = '0; f_be = '0; pend_rd = '0;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        cyc = 0; gcnt = 0; rcnt = -1;
        while (!got_rsp && cyc < 100) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            req_addr  = $urandom;
            m_gnt     = 1'b0;
            m_rvalid  = 1'b0;
            m_rdata   = $urandom;
            if (rsp_valid) begin
                got_rsp = 1'b1; rsp_cyc = cyc; rsp_rd = rsp_rdata; rsp_er = rsp_err;
            end else if (rcnt == 0) begin
                m_rvalid = 1'b1; m_rdata = pend_rd; rcnt = -1;
            end else if (rcnt > 0) begin
                rcnt--;
            end else if (m_req) begin
                if (!seen) begin
                    seen = 1'b1; f_addr = m_addr; f_be = m_byteen; f_wd = m_wdata;
                end
                if (gcnt < gd) begin
                    gcnt++;
                end else begin
                    if (gd > 0) begin
                        check("stable_addr", m_addr, f_addr);
                        check("stable_be", m_byteen, f_be);
                        check("stable_wdata", m_wdata, f_wd);
                    end
                    m_gnt = 1'b1;
                    if (beat_cnt < 2) begin
                        beat_addr[beat_cnt] = m_addr;
                        beat_be[beat_cnt]   = m_byteen;
                        beat_wd[beat_cnt]   = m_wdata;
                    end
                    beat_cnt++;
                    for (int i = 0; i < 4; i++) begin
                        if (m_we && m_byteen[i]) slave_mem[m_addr + 32'(i)] = m_wdata[8*i +: 8];
                        pend_rd[8*i +: 8] = slave_byte(m_addr + 32'(i));
                    end
                    rcnt = rvd; gcnt = 0; seen = 1'b0;
                end
            end
        end
        m_gnt = 1'b0; m_rvalid = 1'b0;
        if (!got_rsp) check("rsp_timeout", 0, 1);
    endtask

    task automatic run_one(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input int gd, input int rvd);
        logic        err_e;
        int          beats_e;
        logic [31:0] rd_e;
        int          mism;
        ref_access(we, sz, uns, addr, wd, err_e, beats_e, rd_e);
        exp_q.push_back(rd_e);
        do_access(we, sz, uns, addr, wd, gd, rvd);
        if (got_rsp) begin
            check($sformatf("%s.rdata", tag), rsp_rd, exp_q.pop_front());
            check($sformatf("%s.err", tag), rsp_er, err_e);
            check($sformatf("%s.beats", tag), beat_cnt, beats_e);
            check($sformatf("%s.latency", tag), rsp_cyc, 1 + beats_e * (2 + gd + rvd));
            mism = 0;
            for (int k = -4; k < 8; k++) begin
                if (slave_byte(addr + 32'(k)) !== ref_byte(addr + 32'(k))) mism++;
            end
            check($sformatf("%s.mem", tag), mism, 0);
        end else begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        check($sformatf("%s.rsp_pulse", tag), rsp_valid, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n_rsp;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", req_ready, 0);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.m_req", m_req, 0);
        check("rst.bus", {m_addr, m_byteen, m_wdata, m_we}, 0);
        check("rst.rsp", {rsp_rdata, rsp_err}, 0);
        reset = 1'b1;

        // Plan 1: aligned word load, minimum latency.
        put_word(32'h100, 32'h8000_00F0);
        run_one("t1", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0);
        check("t1.addr", beat_addr[0], 32'h100);
        check("t1.be", beat_be[0], 4'b1111);
        check("t1.rdata_lit", rsp_rd, 32'h8000_00F0);
        check("t1.lat_lit", rsp_cyc, 3);

        // Plan 2: signed and unsigned byte at 0x103.
        put_word(32'h100, 32'h8A00_0000);
        run_one("t2s", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0);
        check("t2s.rdata_lit", rsp_rd, 32'hFFFF_FF8A);
        run_one("t2u", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 1);
        check("t2u.rdata_lit", rsp_rd, 32'h0000_008A);

`ifndef LSU_MISALIGN_TRAP_EN
        // Plan 3: word store crossing the boundary.
        run_one("t3", 1'b1, 2'd2, 1'b0, 32'h102, 32'hAABB_CCDD, 0, 0);
        check("t3.addr0", beat_addr[0], 32'h100);
        check("t3.be0", beat_be[0], 4'b1100);
        check("t3.wd0", beat_wd[0], 32'hCCDD_0000);
        check("t3.addr1", beat_addr[1], 32'h104);
        check("t3.be1", beat_be[1], 4'b0011);
        check("t3.wd1", beat_wd[1], 32'h0000_AABB);
        check("t3.lat_lit", rsp_cyc, 5);

        // Plan 4: half load at top of address space wraps to 0.
        put_word(32'hFFFF_FFFC, 32'h1200_0000);
        put_word(32'h0000_0000, 32'h0000_0034);
        run_one("t4", 1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 0, 0);
        check("t4.addr1", beat_addr[1], 32'h0);
        check("t4.rdata_lit", rsp_rd, 32'h0000_3412);
`else
        run_one("t6trap", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0, 0);
        check("t6trap.err_lit", rsp_er, 1);
        check("t6trap.beats_lit", beat_cnt, 0);
`endif

        // Plan 6: illegal size on a 32-bit bus.
        run_one("t6", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 0);
        check("t6.err_lit", rsp_er, 1);
        check("t6.beats_lit", beat_cnt, 0);

        // Plan 5: delayed gnt, then async reset while waiting for rvalid.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h104;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5.req_held", m_req, 1);
            check("t5.addr_held", m_addr, 32'h104);
            @(negedge clk);
        end
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        check("t5.wait_no_req", m_req, 0);
        #1 reset = 1'b0;
        #1;
        check("t5.rst_outs", {req_ready, rsp_valid, rsp_err, m_req, m_we, m_byteen}, 0);
        check("t5.rst_data", {m_addr, m_wdata, rsp_rdata}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        n_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m_rvalid = 1'b0;
            if (rsp_valid || m_req) n_rsp++;
        end
        check("t5.stray_ignored", n_rsp, 0);
        check("t5.ready_after", req_ready, 1);

        // Randomized accesses against the reference memory.
        for (int n = 0; n < 120; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                             : 32'h200 + 32'($urandom_range(0, 63));
            run_one($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Parametrised successor to the datapath byte-enable/extension unit.
- Sits between the MEM stage and the data bus and presents a valid/ready load/store request port.
- Generates byte enables, shifted write data, and sign/zero-extended load data for a configurable bus width.
- Splits any access that crosses a bus-word boundary into two sequential bus transactions, then merges the read halves.

Parameters:
- DATA_W, 32: bus width in bits; legal values 32 or 64. NB = DATA_W/8.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  CPU request valid.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse when the access completes.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  1  valid with rsp_valid; illegal size.
- m_req  out  1  bus request.
- m_gnt  in  1  bus accepts the request this cycle.
- m_we  out  1  bus write.
- m_addr  out  ADDR_W  bus-word-aligned address (low log2(NB) bits 0).
- m_byteen  out  NB  byte enables.
- m_wdata  out  DATA_W  lane-positioned write data.
- m_rvalid  in  1  read data / write acknowledge, at least 1 cycle after m_gnt.
- m_rdata  in  DATA_W  read data.

Behaviour:
- Reset: all outputs 0; state = IDLE; latched request cleared. Reset is asynchronous and may hit mid-transaction: the unit returns to IDLE with no response, and any later stray m_rvalid is ignored.
- FSM states: IDLE -> REQ0 -> WAIT0 -> (REQ1 -> WAIT1) -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request.
  - Illegal size -> RESP with rsp_err=1 and no bus activity.
  - Otherwise -> REQ0.
- REQn: assert m_req with stable m_addr, m_byteen, m_wdata and m_we until m_gnt. The gnt cycle moves to WAITn.
- WAITn:
  - Hold until m_rvalid.
  - Beat 0 captures m_rdata into hold register lo.
  - If split, go to REQ1; else go to RESP.
  - Beat 1 captures into register hi.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Minimum latency, aligned access with immediate m_gnt and m_rvalid one cycle after m_gnt:
  - T: accept.
  - T+1: m_req.
  - T+2: m_rvalid.
  - T+3: rsp_valid.
- Split adds 2 cycles.
- Lane arithmetic: off = addr mod NB; S = 1<<size; mask = (2^S - 1) << off over 2*NB bits.
- Split condition: split iff off + S > NB. Misaligned-within-word (e.g. half at off=1) is a single beat.
- Beat 0:
  - m_addr = addr with low bits cleared.
  - m_byteen = mask[NB-1:0].
  - m_wdata = wdata << 8*off.
- Beat 1:
  - m_addr = beat-0 addr + NB, wrapping modulo 2^ADDR_W.
  - m_byteen = mask[2NB-1:NB].
  - m_wdata = wdata >> 8*(NB-off).
- Load merge: raw = ({hi,lo} >> 8*off), truncated to S bytes, then sign/zero-extended to DATA_W.
- Stores: rsp_rdata = 0; completion still waits for m_rvalid ack.
- m_rvalid in any state other than WAITn is ignored. m_gnt outside REQn is ignored.
- req_valid while not IDLE is not accepted.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Any access with off mod S != 0 goes IDLE -> RESP with rsp_err=1 and m_req never asserted.
  - Split logic is not compiled.
  - Naturally aligned accesses are unchanged.
- Undefined: behaviour as above, where misaligned accesses are legal and split when crossing a word.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - FSM state typedef.
  - function returning NB-derived shift widths.
- Sub-module lsu_lane_shift, combinational:
  - Inputs: off, size, wdata, {hi,lo}.
  - Outputs: both beat masks, both beat wdata values, the split flag, and extended rdata.
- The FSM/handshake stays in lsu_align_unit.

Test Plan:
1. DATA_W=32, load word at 0x100, m_rdata=0x8000_00F0 -> m_addr=0x100, byteen 1111, rsp_rdata 0x8000_00F0 at T+3.
2. Signed byte load at 0x103 and unsigned byte load at 0x103, m_rdata=0x8A00_0000 -> rsp_rdata 0xFFFF_FF8A and 0x0000_008A respectively.
3. Store word 0xAABB_CCDD at 0x102 -> beat0 addr 0x100 byteen 1100 wdata 0xCCDD_0000; beat1 addr 0x104 byteen 0011 wdata 0x0000_AABB.
4. Load half at 0xFFFF_FFFF, lo=0x1200_0000, hi=0x0000_0034 -> beat1 addr 0x0000_0000 (wrap), rsp_rdata 0x0000_3412 (signed).
5. m_gnt delayed 3 cycles; reset asserted during WAIT0 -> m_req held stable until gnt; after reset, all outputs 0, no rsp_valid, stray m_rvalid ignored.
6. DATA_W=32 size=3 -> rsp_err=1 with no m_req. With LSU_MISALIGN_TRAP_EN, half at 0x101 -> rsp_err=1.
